// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: reads opcode plus 0-2 operand bytes and presents them to the decoder.
// Optional RESET_VECTOR_FETCH_EN: load the starting fetch PC from $FFFC/$FFFD after reset.
module inst_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'hC000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [7:0]  opcode,
    output logic [7:0]  operand_lo,
    output logic [7:0]  operand_hi,
    output logic [1:0]  op_len,
    output logic [15:0] op_pc,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc
);

`ifdef RESET_VECTOR_FETCH_EN
    typedef enum logic [2:0] {F_OP, F_B1, F_B2, F_B3, PRESENT, V_LO, V_HI, V_LD} state_t;
`else
    typedef enum logic [2:0] {F_OP, F_B1, F_B2, F_B3, PRESENT} state_t;
`endif

    state_t      state, state_nx;
    logic [15:0] fpc;
    logic        rd;
    logic [15:0] addr;
    logic        in_vec;
    logic        redir;
    logic [1:0]  rdata_len;

    function automatic logic [1:0] plen(input logic [7:0] b);
        if (b == 8'h20)                                          return 2'd3;
        else if (b == 8'h00 || b == 8'h40 || b == 8'h60)         return 2'd1;
        else if (b[4:0] == 5'b10000)                             return 2'd2;
        else if (b[3:0] == 4'b1000)                              return 2'd1;
        else if (b[1:0] == 2'b10 && (b[4:2] == 3'b010 || b[4:2] == 3'b110))
                                                                 return 2'd1;
        else if (b[4:2] == 3'b011 || b[4:2] == 3'b111)           return 2'd3;
        else if (b[4:2] == 3'b110)                               return 2'd3;
        else                                                     return 2'd2;
    endfunction

    assign rdata_len = plen(mem_rdata);

`ifdef RESET_VECTOR_FETCH_EN
    assign in_vec = (state == V_LO) || (state == V_HI) || (state == V_LD);
`else
    assign in_vec = 1'b0;
`endif

    // Redirects cannot interrupt the vector fetch; otherwise they override everything.
    assign redir = redirect_valid && !in_vec;

    always_comb begin
        state_nx = state;
        rd       = 1'b0;
        addr     = fpc;
        case (state)
            F_OP: begin
                rd       = 1'b1;
                state_nx = F_B1;
            end
            F_B1: begin
                if (rdata_len >= 2'd2) begin
                    rd       = 1'b1;
                    addr     = fpc + 16'd1;
                    state_nx = F_B2;
                end else begin
                    state_nx = PRESENT;
                end
            end
            F_B2: begin
                if (op_len == 2'd3) begin
                    rd       = 1'b1;
                    addr     = fpc + 16'd2;
                    state_nx = F_B3;
                end else begin
                    state_nx = PRESENT;
                end
            end
            F_B3:    state_nx = PRESENT;
            PRESENT: if (op_ready) state_nx = F_OP;
`ifdef RESET_VECTOR_FETCH_EN
            V_LO: begin
                rd       = 1'b1;
                addr     = 16'hFFFC;
                state_nx = V_HI;
            end
            V_HI: begin
                rd       = 1'b1;
                addr     = 16'hFFFD;
                state_nx = V_LD;
            end
            V_LD:    state_nx = F_OP;
`endif
            default: state_nx = F_OP;
        endcase
        if (redir) state_nx = F_OP;
    end

    // The reset state still decodes as a read, so mask the strobe while rst is held.
    assign mem_rd   = rd && !rst;
    assign mem_addr = mem_rd ? addr : 16'h0000;
    assign op_valid = (state == PRESENT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef RESET_VECTOR_FETCH_EN
            state <= V_LO;
            fpc   <= 16'h0000;
`else
            state <= F_OP;
            fpc   <= RESET_PC;
`endif
            opcode     <= 8'h00;
            operand_lo <= 8'h00;
            operand_hi <= 8'h00;
            op_len     <= 2'd1;
            op_pc      <= 16'h0000;
        end else begin
            state <= state_nx;
            if (redir) begin
                fpc <= redirect_pc;
            end else begin
                case (state)
                    F_B1: begin
                        opcode     <= mem_rdata;
                        op_len     <= rdata_len;
                        operand_lo <= 8'h00;
                        operand_hi <= 8'h00;
                        op_pc      <= fpc;
                    end
                    F_B2:    operand_lo <= mem_rdata;
                    F_B3:    operand_hi <= mem_rdata;
                    PRESENT: if (op_ready) fpc <= fpc + {14'd0, op_len};
`ifdef RESET_VECTOR_FETCH_EN
                    V_HI:    fpc[7:0]  <= mem_rdata;
                    V_LD:    fpc[15:8] <= mem_rdata;
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed corner sequences, a length table, and a randomized run
// against a byte-array memory and an instruction-level model.
module tb_inst_fetch_unit;
    logic        clk;
    logic        rst;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  opcode;
    logic [7:0]  operand_lo;
    logic [7:0]  operand_hi;
    logic [1:0]  op_len;
    logic [15:0] op_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    logic [7:0] mem [0:65535];
    int total = 0;
    int passed = 0;

    inst_fetch_unit dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode), .operand_lo(operand_lo),
        .operand_hi(operand_hi), .op_len(op_len), .op_pc(op_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    typedef struct {
        logic [7:0] op;
        int         len;
    } vec_t;

    function automatic int ref_len(input logic [7:0] b);
        if (b == 8'h20) return 3;
        if (b inside {8'h00, 8'h40, 8'h60}) return 1;
        if (b[4:0] == 5'b10000) return 2;
        if (b[3:0] == 4'b1000) return 1;
        if (b[1:0] == 2'b10 && (b[4:2] inside {3'b010, 3'b110})) return 1;
        if (b[4:2] inside {3'b011, 3'b111, 3'b110}) return 3;
        return 2;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        mid();
        while (!op_valid && n < 20) begin
            tick();
            mid();
            n++;
        end
        chk({nm, "_valid"}, {31'd0, op_valid}, 32'd1);
    endtask

    task automatic do_redirect(input logic [15:0] pc, input logic rdy);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        op_ready       = rdy;
        mid();
        tick();
        redirect_valid = 1'b0;
        op_ready       = 1'b0;
    endtask

    vec_t tbl [18];

    initial begin
        logic [15:0] exp_pc, a;
        int          waits, reads, el;
        logic        first;
        logic [7:0]  e_lo, e_hi;

        tbl[0]  = '{8'h20, 3}; tbl[1]  = '{8'h00, 1}; tbl[2]  = '{8'h40, 1};
        tbl[3]  = '{8'h60, 1}; tbl[4]  = '{8'h10, 2}; tbl[5]  = '{8'h90, 2};
        tbl[6]  = '{8'h08, 1}; tbl[7]  = '{8'h18, 1}; tbl[8]  = '{8'h0A, 1};
        tbl[9]  = '{8'h1A, 1}; tbl[10] = '{8'h0C, 3}; tbl[11] = '{8'h1D, 3};
        tbl[12] = '{8'h19, 3}; tbl[13] = '{8'h01, 2}; tbl[14] = '{8'hA9, 2};
        tbl[15] = '{8'hEA, 1}; tbl[16] = '{8'hAD, 3}; tbl[17] = '{8'h05, 2};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        rst = 1'b1; op_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;

        // ---- reset state and first fetch
        mid();
        chk("rst_op_valid", {31'd0, op_valid}, 0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 0);
        chk("rst_opcode", {24'd0, opcode}, 0);
        chk("rst_op_len", {30'd0, op_len}, 1);
        chk("rst_op_pc", {16'd0, op_pc}, 0);
`ifdef RESET_VECTOR_FETCH_EN
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80; mem[16'h8000] = 8'hEA;
        tick(); rst = 1'b0;
        mid(); chk("vec_rd0", {15'd0, mem_rd, mem_addr}, {16'd1, 16'hFFFC}); tick();
        mid(); chk("vec_rd1", {15'd0, mem_rd, mem_addr}, {16'd1, 16'hFFFD}); tick();
        mid(); chk("vec_ld_nord", {31'd0, mem_rd}, 0); tick();
        mid(); chk("vec_first", {15'd0, mem_rd, mem_addr}, {16'd1, 16'h8000}); tick();
        mid(); tick();
        mid();
        chk("vec_valid", {31'd0, op_valid}, 1);
        chk("vec_op_pc", {16'd0, op_pc}, 32'h8000);
`else
        mem[16'hC000] = 8'hEA;
        tick(); rst = 1'b0;
        mid(); chk("r_rd0", {15'd0, mem_rd, mem_addr}, {16'd1, 16'hC000}); tick();
        mid(); chk("r_c1_novalid", {31'd0, op_valid}, 0); tick();
        mid();
        chk("r_valid", {31'd0, op_valid}, 1);
        chk("r_opcode", {24'd0, opcode}, 32'hEA);
        chk("r_len", {30'd0, op_len}, 1);
        chk("r_op_pc", {16'd0, op_pc}, 32'hC000);
        chk("r_operands", {16'd0, operand_hi, operand_lo}, 0);
`endif
        tick();

        // ---- 3-byte op, back-to-back reads; redirect with op_ready drops the held op
        mem[16'hC000] = 8'hAD; mem[16'hC001] = 8'h34; mem[16'hC002] = 8'h12; mem[16'hC003] = 8'hEA;
        do_redirect(16'hC000, 1'b1);
        op_ready = 1'b1;
        mid(); chk("t2_rd0", {15'd0, mem_rd, mem_addr}, {16'd1, 16'hC000}); tick();
        mid(); chk("t2_rd1", {15'd0, mem_rd, mem_addr}, {16'd1, 16'hC001}); tick();
        mid(); chk("t2_rd2", {15'd0, mem_rd, mem_addr}, {16'd1, 16'hC002}); tick();
        mid(); chk("t2_b3", {30'd0, mem_rd, op_valid}, 0); tick();
        mid();
        chk("t2_valid", {31'd0, op_valid}, 1);
        chk("t2_fields", {opcode, operand_lo, operand_hi, 6'd0, op_len}, {8'hAD, 8'h34, 8'h12, 8'd3});
        tick();
        mid(); chk("t2_next_rd", {15'd0, mem_rd, mem_addr}, {16'd1, 16'hC003}); tick();
        mid(); tick();
        mid();
        op_ready = 1'b0;
        chk("t2_next_pc", {15'd0, op_valid, op_pc}, {16'd1, 16'hC003});
        tick();

        // ---- back-pressure
        mem[16'h0300] = 8'hA9; mem[16'h0301] = 8'h05; mem[16'h0302] = 8'hEA;
        do_redirect(16'h0300, 1'b0);
        wait_valid("t3");
        chk("t3_fields", {opcode, operand_lo, operand_hi, 6'd0, op_len}, {8'hA9, 8'h05, 8'h00, 8'd2});
        tick();
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("t3_hold", {op_valid, mem_rd, opcode, operand_lo, 6'd0, op_len, 6'd0},
                {2'b10, 8'hA9, 8'h05, 8'd2, 6'd0});
            chk("t3_hold_pc", {16'd0, op_pc}, 32'h0300);
            tick();
        end
        op_ready = 1'b1;
        mid(); tick();
        op_ready = 1'b0;
        wait_valid("t3b");
        chk("t3_next_pc", {16'd0, op_pc}, 32'h0302);
        tick();

        // ---- redirect in F_B2, then redirect concurrent with op_ready
        mem[16'h0400] = 8'h20; mem[16'h0401] = 8'h00; mem[16'h0402] = 8'h80;
        mem[16'h0200] = 8'hEA; mem[16'h0500] = 8'hEA;
        do_redirect(16'h0400, 1'b0);
        mid(); tick();
        mid(); tick();
        redirect_valid = 1'b1; redirect_pc = 16'h0200;
        mid(); chk("t4_in_b2", {15'd0, mem_rd, mem_addr}, {16'd1, 16'h0402}); tick();
        redirect_valid = 1'b0;
        mid(); chk("t4_rd", {15'd0, mem_rd, mem_addr}, {16'd1, 16'h0200}); tick();
        mid(); tick();
        mid();
        chk("t4_valid", {31'd0, op_valid}, 1);
        chk("t4_fields", {opcode, operand_lo, operand_hi, 6'd0, op_len}, {8'hEA, 16'h0000, 8'd1});
        chk("t4_pc", {16'd0, op_pc}, 32'h0200);
        tick();
        do_redirect(16'h0500, 1'b1);
        mid(); chk("t4_drop_rd", {15'd0, mem_rd, mem_addr}, {16'd1, 16'h0500});
        wait_valid("t4b");
        chk("t4_drop_pc", {16'd0, op_pc}, 32'h0500);
        tick();

        // ---- address wrap
        mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'h00; mem[16'h0001] = 8'hEA;
        do_redirect(16'hFFFE, 1'b0);
        mid(); chk("t5_rd0", {15'd0, mem_rd, mem_addr}, {16'd1, 16'hFFFE}); tick();
        mid(); chk("t5_rd1", {15'd0, mem_rd, mem_addr}, {16'd1, 16'hFFFF}); tick();
        mid(); chk("t5_rd2", {15'd0, mem_rd, mem_addr}, {16'd1, 16'h0000});
        wait_valid("t5");
        chk("t5_fields", {opcode, 6'd0, op_len, op_pc}, {8'h4C, 8'd3, 16'hFFFE});
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        wait_valid("t5b");
        chk("t5_next_pc", {16'd0, op_pc}, 32'h0001);
        tick();

        // ---- length pre-decode table
        for (int i = 0; i < 18; i++) begin
            a = 16'h1000 + 16'(i * 4);
            mem[a] = tbl[i].op;
            mem[a + 16'd1] = 8'(i + 1);
            mem[a + 16'd2] = 8'h80 | 8'(i);
            do_redirect(a, 1'b0);
            wait_valid("tbl");
            e_lo = (tbl[i].len >= 2) ? 8'(i + 1) : 8'h00;
            e_hi = (tbl[i].len == 3) ? (8'h80 | 8'(i)) : 8'h00;
            chk($sformatf("tbl_len_%02h", tbl[i].op), {30'd0, op_len}, 32'(tbl[i].len));
            chk($sformatf("tbl_ops_%02h", tbl[i].op), {opcode, operand_lo, operand_hi, 8'd0},
                {tbl[i].op, e_lo, e_hi, 8'd0});
            tick();
        end

        // ---- randomized run against an instruction-level model
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        exp_pc = 16'h0000; waits = 0; reads = 0; first = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            redirect_valid = (cyc == 0) || ($urandom_range(0, 99) < 3);
            redirect_pc    = 16'($urandom);
            op_ready       = ($urandom_range(0, 99) < 70);
            mid();
            if (redirect_valid) begin
                exp_pc = redirect_pc; waits = 0; reads = 0; first = 1'b1;
            end else if (op_valid) begin
                el = ref_len(mem[exp_pc]);
                e_lo = (el >= 2) ? mem[exp_pc + 16'd1] : 8'h00;
                e_hi = (el == 3) ? mem[exp_pc + 16'd2] : 8'h00;
                if (first) begin
                    chk("rnd_latency", 32'(waits), 32'(el + 1));
                    chk("rnd_reads", 32'(reads), 32'(el));
                    first = 1'b0;
                end
                chk("rnd_nord", {31'd0, mem_rd}, 0);
                chk("rnd_fields", {opcode, operand_lo, operand_hi, 6'd0, op_len},
                    {mem[exp_pc], e_lo, e_hi, 8'(el)});
                chk("rnd_pc", {16'd0, op_pc}, {16'd0, exp_pc});
                if (op_ready) begin
                    exp_pc = exp_pc + 16'(el); waits = 0; reads = 0; first = 1'b1;
                end
            end else begin
                if (mem_rd) begin
                    chk("rnd_addr", {16'd0, mem_addr}, {16'd0, exp_pc + 16'(reads)});
                    reads++;
                end
                waits++;
            end
            tick();
        end
        redirect_valid = 1'b0;
        op_ready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
